imm_encoder: RTL

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// Encodes a 32-bit immediate or branch offset into a 24-bit instruction field; result with a one-cycle done pulse.
// Optional IMM_ROTATE_EN: type 00 searches 16 even rotations (one per cycle) for an 8-bit rotated immediate.
module imm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic [1:0]  instr_type,
  output logic [23:0] imm_field,
  output logic        encodable,
  output logic        error,
  output logic        busy,
  output logic        done
);

`ifdef IMM_ROTATE_EN
  typedef enum logic [1:0] {IDLE, CHECK, SEARCH} state_t;
`else
  typedef enum logic {IDLE, CHECK} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [1:0]  type_q, type_d;
  logic [23:0] imm_q, imm_d;
  logic        enc_q, enc_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic [23:0] chk_imm;
  logic        chk_enc;
  logic        chk_err;

`ifdef IMM_ROTATE_EN
  logic [3:0]  rot_q, rot_d;
  logic [63:0] rot_dbl;
  logic [31:0] rot_val;
  logic        rot_match;

  // Upper half of the shifted doubled word is the left rotation.
  assign rot_dbl   = {val_q, val_q} << {rot_q, 1'b0};
  assign rot_val   = rot_dbl[63:32];
  assign rot_match = ~|rot_val[31:8];
`endif

  always_comb begin
    chk_imm = 24'h0;
    chk_enc = 1'b0;
    chk_err = 1'b0;
    case (type_q)
      2'b00: begin
        chk_enc = ~|val_q[31:8];
        chk_imm = {16'h0, val_q[7:0]};
      end
      2'b01: begin
        chk_enc = ~|val_q[31:12];
        chk_imm = {12'h0, val_q[11:0]};
      end
      2'b10: begin
        chk_enc = (val_q[1:0] == 2'b00) && ((&val_q[31:25]) || (~|val_q[31:25]));
        chk_imm = val_q[25:2];
      end
      default: begin
        chk_err = 1'b1;
      end
    endcase
    if (!chk_enc) chk_imm = 24'h0;
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    type_d  = type_q;
    imm_d   = imm_q;
    enc_d   = enc_q;
    err_d   = err_q;
    done_d  = 1'b0;
`ifdef IMM_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          val_d   = value;
          type_d  = instr_type;
          imm_d   = 24'h0;
          enc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = CHECK;
`ifdef IMM_ROTATE_EN
          rot_d   = 4'd0;
          if (instr_type == 2'b00) state_d = SEARCH;
`endif
        end
      end
      CHECK: begin
        imm_d   = chk_imm;
        enc_d   = chk_enc;
        err_d   = chk_err;
        done_d  = 1'b1;
        state_d = IDLE;
      end
`ifdef IMM_ROTATE_EN
      SEARCH: begin
        if (rot_match) begin
          imm_d   = {12'h0, rot_q, rot_val[7:0]};
          enc_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (rot_q == 4'd15) begin
          imm_d   = 24'h0;
          enc_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          rot_d   = rot_q + 4'd1;
        end
      end
      default: state_d = IDLE;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= 32'h0;
      type_q  <= 2'b00;
      imm_q   <= 24'h0;
      enc_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMM_ROTATE_EN
      rot_q   <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      type_q  <= type_d;
      imm_q   <= imm_d;
      enc_q   <= enc_d;
      err_q   <= err_d;
      done_q  <= done_d;
`ifdef IMM_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign imm_field = imm_q;
  assign encodable = enc_q;
  assign error     = err_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule
